instr_decode_stage: RTL and testbench

Registered, flow-controlled instruction field decoder for the MIPS pipeline, sitting between fetch and register read. Accepts one 32-bit instruction plus its PC per valid/ready handshake, splits it into fields, and produces an extended immediate and jump target. Results are held in a 2-entry skid buffer, so full throughput is kept under backpressure. Supports flush on branch/exception redirect and a parametrised datapath width.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/skid_buffer.sv | 82 ++++++++
 rtl/instr_decode_stage.sv | 100 ++++++++++
 tb/tb_instr_decode_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode constants and the decoded-record layout.
// Wide fields are sized for the largest legal XLEN; narrower stages use the low bits.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam int XLEN_MAX = 64;

  typedef struct packed {
    logic [5:0]          op;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [4:0]          shamt;
    logic [5:0]          funct;
    logic [XLEN_MAX-1:0] imm_ext;
    logic [XLEN_MAX-1:0] jtarget;
    logic [XLEN_MAX-1:0] pc;
    logic                is_rtype;
    logic                is_nop;
  } decoded_t;

  // Logical immediates are zero-extended rather than sign-extended.
  function automatic logic is_zext_op(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry skid buffer: main entry drives the outputs, skid entry absorbs one
// extra record so in_ready can be a pure register.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t       state_r;
  logic [W-1:0] main_r;
  logic [W-1:0] skid_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         acc_s;
  logic         con_s;

  assign acc_s     = in_valid && in_ready_r;
  assign con_s     = out_valid_r && out_ready;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;

  // Occupancy FSM; handshake flags are updated alongside the state they mirror.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= EMPTY;
      main_r      <= {W{1'b0}};
      skid_r      <= {W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else if (flush) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (acc_s) begin
            main_r      <= in_data;
            state_r     <= ONE;
            out_valid_r <= 1'b1;
          end
        end
        ONE: begin
          if (acc_s && !con_s) begin
            skid_r     <= in_data;
            state_r    <= FULL;
            in_ready_r <= 1'b0;
          end else if (con_s && !acc_s) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
          end else if (acc_s) begin
            main_r <= in_data;
          end
        end
        FULL: begin
          if (con_s) begin
            main_r     <= skid_r;
            state_r    <= ONE;
            in_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= EMPTY;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// MIPS instruction field decoder: combinational decode of the incoming word,
// result held in a two-entry skid buffer with flush support.
module instr_decode_stage
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      out_op,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_shamt,
  output logic [5:0]      out_funct,
  output logic [XLEN-1:0] out_imm_ext,
  output logic [XLEN-1:0] out_jtarget,
  output logic [XLEN-1:0] out_pc,
  output logic            out_is_rtype,
  output logic            out_is_nop
);

  decoded_t        dec_s;
  decoded_t        head_s;
  logic [15:0]     imm16_s;
  logic [31:0]     lui_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] p4_s;
  logic [XLEN-1:0] jt_s;
  logic            unused_s;

  assign imm16_s = in_instr[15:0];
  assign lui_s   = {imm16_s, 16'h0000};
  assign p4_s    = in_pc + XLEN'(32'd4);
  assign jt_s    = {p4_s[XLEN-1:28], in_instr[25:0], 2'b00};

  // Immediate extension chosen by opcode.
  always_comb begin
    imm_s = XLEN'($signed(imm16_s));
    if (is_zext_op(in_instr[31:26])) begin
      imm_s = XLEN'(imm16_s);
    end else if (in_instr[31:26] == OP_LUI) begin
      imm_s = XLEN'($signed(lui_s));
    end else begin
      imm_s = XLEN'($signed(imm16_s));
    end
  end

  // Assemble the decoded record for the buffer.
  always_comb begin
    dec_s.op       = in_instr[31:26];
    dec_s.rs       = in_instr[25:21];
    dec_s.rt       = in_instr[20:16];
    dec_s.rd       = in_instr[15:11];
    dec_s.shamt    = in_instr[10:6];
    dec_s.funct    = in_instr[5:0];
    dec_s.imm_ext  = XLEN_MAX'(imm_s);
    dec_s.jtarget  = XLEN_MAX'(jt_s);
    dec_s.pc       = XLEN_MAX'(in_pc);
    dec_s.is_rtype = (in_instr[31:26] == OP_RTYPE);
    dec_s.is_nop   = (in_instr == 32'h0000_0000);
  end

  skid_buffer #(
    .W($bits(decoded_t))
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_s)
  );

  assign out_op       = head_s.op;
  assign out_rs       = head_s.rs;
  assign out_rt       = head_s.rt;
  assign out_rd       = head_s.rd;
  assign out_shamt    = head_s.shamt;
  assign out_funct    = head_s.funct;
  assign out_imm_ext  = head_s.imm_ext[XLEN-1:0];
  assign out_jtarget  = head_s.jtarget[XLEN-1:0];
  assign out_pc       = head_s.pc[XLEN-1:0];
  assign out_is_rtype = head_s.is_rtype;
  assign out_is_nop   = head_s.is_nop;

  // Upper record bits beyond XLEN and the low PC+4 bits are intentionally dropped.
  assign unused_s = ^{head_s.imm_ext, head_s.jtarget, head_s.pc, p4_s[27:0]};

endmodule

// File: tb/tb_instr_decode_stage.sv
// Randomised scoreboard bench for instr_decode_stage plus the directed decode,
// backpressure, flush and reset scenarios.
module tb_instr_decode_stage;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic [31:0] jt;
    logic [31:0] pc;
    logic        rtype;
    logic        nop;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [5:0]  out_op, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [31:0] out_imm_ext, out_jtarget, out_pc;
  logic        out_is_rtype, out_is_nop;

  logic        flush64, in64_valid, in64_ready, out64_valid, out64_ready;
  logic [31:0] in64_instr;
  logic [63:0] in64_pc, out64_imm, out64_jt, out64_pc;
  logic [5:0]  out64_op, out64_funct;
  logic [4:0]  out64_rs, out64_rt, out64_rd, out64_shamt;
  logic        out64_rtype, out64_nop;

  instr_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_shamt(out_shamt), .out_funct(out_funct), .out_imm_ext(out_imm_ext),
    .out_jtarget(out_jtarget), .out_pc(out_pc), .out_is_rtype(out_is_rtype),
    .out_is_nop(out_is_nop));

  instr_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush64), .in_valid(in64_valid), .in_ready(in64_ready),
    .in_instr(in64_instr), .in_pc(in64_pc), .out_valid(out64_valid), .out_ready(out64_ready),
    .out_op(out64_op), .out_rs(out64_rs), .out_rt(out64_rt), .out_rd(out64_rd),
    .out_shamt(out64_shamt), .out_funct(out64_funct), .out_imm_ext(out64_imm),
    .out_jtarget(out64_jt), .out_pc(out64_pc), .out_is_rtype(out64_rtype),
    .out_is_nop(out64_nop));

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t q[$];
  exp_t prev_vec;
  bit   hold_pend = 1'b0;
  logic [5:0] ops [0:6] = '{6'h00, 6'h02, 6'h03, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

  function automatic exp_t act_vec();
    return {out_op, out_rs, out_rt, out_rd, out_shamt, out_funct,
            out_imm_ext, out_jtarget, out_pc, out_is_rtype, out_is_nop};
  endfunction

  function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference decoder written from the field/extension rules with plain arithmetic.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] p);
    exp_t e;
    logic [31:0] imm16;
    e.op    = 6'((i >> 26) & 32'h3F);
    e.rs    = 5'((i >> 21) & 32'h1F);
    e.rt    = 5'((i >> 16) & 32'h1F);
    e.rd    = 5'((i >> 11) & 32'h1F);
    e.shamt = 5'((i >> 6) & 32'h1F);
    e.funct = 6'(i & 32'h3F);
    imm16   = i & 32'hFFFF;
    if (e.op == 6'd12 || e.op == 6'd13 || e.op == 6'd14) e.imm = imm16;
    else if (e.op == 6'd15) e.imm = imm16 << 16;
    else if (imm16 >= 32'h8000) e.imm = imm16 + 32'hFFFF_0000;
    else e.imm = imm16;
    e.jt    = ((p + 32'd4) & 32'hF000_0000) | ((i & 32'h03FF_FFFF) << 2);
    e.pc    = p;
    e.rtype = (e.op == 6'd0);
    e.nop   = (i == 32'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k < 7) r[31:26] = ops[k];
    else if (k == 9) r = 32'd0;
    return r;
  endfunction

  // Monitor/scoreboard: occupancy, in-order records, and hold stability under stall.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid_occupancy", 256'(out_valid), 256'(q.size() > 0));
      chk("in_ready_occupancy", 256'(in_ready), 256'(q.size() < 2));
      if (hold_pend) chk("hold_stable", 256'(act_vec()), 256'(prev_vec));
      hold_pend = out_valid && !out_ready && !flush && !reset;
      prev_vec  = act_vec();
      if (q.size() > 0 && out_ready) chk("record", 256'(act_vec()), 256'(q.pop_front()));
      if (flush || reset) q.delete();
      else if (in_valid && in_ready) q.push_back(model(in_instr, in_pc));
    end
  end

  task automatic send(input logic [31:0] i, input logic [31:0] p);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_instr = i; in_pc = p;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) begin
      errors++;
      $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 32'd0;
    flush64 = 1'b0; in64_valid = 1'b0; out64_ready = 1'b1; in64_instr = 32'd0; in64_pc = 64'd0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 256'(out_valid), 256'(1'b0));
    chk("reset_in_ready", 256'(in_ready), 256'(1'b1));
    chk("reset_data", 256'(act_vec()), 256'(0));
    mon_en = 1'b1;
    tick();

    out_ready = 1'b1;
    send(32'h0109_5020, 32'h0000_0100);
    @(negedge clk);
    chk("rtype_fields", 256'({out_op, out_rs, out_rt, out_rd, out_shamt, out_funct, out_is_rtype}),
        256'({6'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 1'b1}));
    send(32'h2008_FFFF, 32'h0000_0104);
    @(negedge clk); chk("addi_imm", 256'(out_imm_ext), 256'(32'hFFFF_FFFF));
    send(32'h3508_FFFF, 32'h0000_0108);
    @(negedge clk); chk("ori_imm", 256'(out_imm_ext), 256'(32'h0000_FFFF));
    send(32'h3C01_1234, 32'h0000_010C);
    @(negedge clk); chk("lui_imm", 256'(out_imm_ext), 256'(32'h1234_0000));
    send(32'h0810_0004, 32'h8000_0000);
    @(negedge clk); chk("j_target", 256'(out_jtarget), 256'(32'h8040_0010));

    in64_valid = 1'b1; in64_instr = 32'h3C01_8000; in64_pc = 64'h0000_0001_0000_0000;
    @(negedge clk); chk("x64_in_ready", 256'(in64_ready), 256'(1'b1));
    tick(); in64_valid = 1'b0;
    @(negedge clk);
    chk("x64_valid", 256'(out64_valid), 256'(1'b1));
    chk("x64_lui_imm", 256'(out64_imm), 256'(64'hFFFF_FFFF_8000_0000));
    tick();

    // Backpressure: three back-to-back inputs with the consumer stalled.
    repeat (3) tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h2001_0001; in_pc = 32'h0000_1000; tick();
    in_instr = 32'h2002_0002; in_pc = 32'h0000_1004; tick();
    in_instr = 32'h2003_0003; in_pc = 32'h0000_1008;
    @(negedge clk); chk("bp_in_ready_low", 256'(in_ready), 256'(1'b0));
    tick();
    out_ready = 1'b1;
    tick();
    @(negedge clk); chk("bp_in_ready_rise", 256'(in_ready), 256'(1'b1));
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // Flush while FULL with a pending input.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h3404_0004; in_pc = 32'h0000_2000; tick();
    in_instr = 32'h3405_0005; in_pc = 32'h0000_2004; tick();
    in_instr = 32'h3406_0006; in_pc = 32'h0000_2008; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_full_out_valid", 256'(out_valid), 256'(1'b0));
    chk("flush_full_in_ready", 256'(in_ready), 256'(1'b1));
    // Flush in ONE while a new record is being accepted: it must be dropped.
    tick();
    in_valid = 1'b1; in_instr = 32'h3807_0007; in_pc = 32'h0000_3000; tick();
    in_instr = 32'h3808_0008; in_pc = 32'h0000_3004; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk); chk("flush_drop_out_valid", 256'(out_valid), 256'(1'b0));
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset mid-stream while FULL.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h2409_FFF0; in_pc = 32'h0000_4000; tick();
    in_instr = 32'h000A_5820; in_pc = 32'h0000_4004; tick();
    in_valid = 1'b0; reset = 1'b1; tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
    chk("rst_data", 256'(act_vec()), 256'(0));
    tick();

    // Randomised traffic with occasional flushes.
    repeat (800) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("drain_empty", 256'(q.size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
